// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter, one shift per clock.
// Optional leading-zero blanking mask enabled by defining BIN_TO_BCD_LEADING_BLANK_EN.
module bin_to_bcd_seq #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [BIN_W-1:0]      bin_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic                  ovf_o,
   output logic [DIGITS-1:0]     digit_blank_o
);
   localparam int CW = $clog2(BIN_W + 1);
   localparam logic IDLE  = 1'b0;
   localparam logic SHIFT = 1'b1;
   logic                state_q, state_d;
   logic [BIN_W-1:0]    sh_q, sh_d, sh_sh;
   logic [4*DIGITS-1:0] scr_q, scr_d, scr_sh, adj, bcd_q, bcd_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                ovs_q, ovs_d, ovf_q, ovf_d, done_q, done_d;
   logic                out_bit, ovf_fin, shifting, last, fin;
   always_comb begin
      adj = scr_q;
      for (int d = 0; d < DIGITS; d++)
         adj[4*d+:4] = (scr_q[4*d+:4] >= 4'd5) ? scr_q[4*d+:4] + 4'd3 : scr_q[4*d+:4];
      {out_bit, scr_sh, sh_sh} = {adj, sh_q, 1'b0};
      ovf_fin  = ovs_q | out_bit;
      shifting = state_q == SHIFT;
      last     = cnt_q == CW'(BIN_W - 1);
      fin      = shifting && last;
      state_d  = shifting ? (last ? IDLE : SHIFT) : (start_i ? SHIFT : IDLE);
      sh_d     = shifting ? sh_sh : (start_i ? bin_i : sh_q);
      scr_d    = shifting ? scr_sh : (start_i ? '0 : scr_q);
      cnt_d    = shifting ? cnt_q + CW'(1) : '0;
      ovs_d    = shifting ? ovf_fin : (start_i ? 1'b0 : ovs_q);
      done_d   = fin;
      bcd_d    = fin ? scr_sh : bcd_q;
      ovf_d    = fin ? ovf_fin : ovf_q;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sh_q    <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         ovs_q   <= 1'b0;
         done_q  <= 1'b0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         ovs_q   <= ovs_d;
         done_q  <= done_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
      end
   end
   assign busy_o = state_q == SHIFT;
   assign done_o = done_q;
   assign bcd_o  = bcd_q;
   assign ovf_o  = ovf_q;
`ifdef BIN_TO_BCD_LEADING_BLANK_EN
   // digit 0 never blanks, so a zero result still shows one "0"
   localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));
   logic [DIGITS-1:0] blank_q, blank_d;
   logic              z;
   always_comb begin
      blank_d = '0;
      z       = ~ovf_fin;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         z          = z & (scr_sh[4*k+:4] == 4'd0);
         blank_d[k] = z;
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         blank_q <= BLANK_RST;
      else if (fin)
         blank_q <= blank_d;
   end
   assign digit_blank_o = blank_q;
`else
   assign digit_blank_o = '0;
`endif
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed bench for bin_to_bcd_seq (5-digit and 4-digit instances).
module tb_bin_to_bcd_seq;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [15:0] bin = '0;
   logic        busy5, done5, ovf5, busy4, done4, ovf4;
   logic [19:0] bcd5;
   logic [15:0] bcd4;
   logic [4:0]  blank5;
   logic [3:0]  blank4;
   int          vecs = 0, errs = 0;
`ifdef BIN_TO_BCD_LEADING_BLANK_EN
   localparam logic [4:0] B0 = 5'b11110, B42 = 5'b11100, B500 = 5'b11000, B1234 = 5'b10000;
   localparam logic [3:0] B4_99 = 4'b1100, B4R = 4'b1110;
`else
   localparam logic [4:0] B0 = 5'b00000, B42 = 5'b00000, B500 = 5'b00000, B1234 = 5'b00000;
   localparam logic [3:0] B4_99 = 4'b0000, B4R = 4'b0000;
`endif
   always #5 clk = ~clk;

   bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u5 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .bin_i(bin),
      .busy_o(busy5), .done_o(done5), .bcd_o(bcd5), .ovf_o(ovf5), .digit_blank_o(blank5));
   bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) u4 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .bin_i(bin),
      .busy_o(busy4), .done_o(done4), .bcd_o(bcd4), .ovf_o(ovf4), .digit_blank_o(blank4));

   // Called at a negedge with the DUT idle; returns at the negedge where done5 is seen.
   task automatic run(input logic [15:0] v, input int inj_k, input logic [15:0] inj_v,
                      output int lat, output int bcnt, output logic held);
      logic [19:0] prev;
      prev  = bcd5;
      held  = 1'b1;
      start = 1'b1;
      bin   = v;
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      bcnt  = int'(busy5);
      while (!done5 && lat < 40) begin
         if (lat == inj_k) begin
            start = 1'b1;
            bin   = inj_v;
         end
         @(negedge clk);
         start = 1'b0;
         lat++;
         bcnt += int'(busy5);
         if (!done5 && bcd5 !== prev) held = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      vecs++; if (busy5 !== 1'b0 || done5 !== 1'b0) begin errs++; $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy5, done5); end
      vecs++; if (bcd5 !== 20'h0 || ovf5 !== 1'b0) begin errs++; $display("FAIL reset_out bcd=%h ovf=%b want 00000 0", bcd5, ovf5); end
      vecs++; if (blank5 !== B0 || blank4 !== B4R) begin errs++; $display("FAIL reset_blank got %b/%b want %b/%b", blank5, blank4, B0, B4R); end
      rst = 1'b0;
      @(negedge clk);
      vecs++; if (busy5 !== 1'b0 || bcd5 !== 20'h0) begin errs++; $display("FAIL post_reset busy=%b bcd=%h want 0 00000", busy5, bcd5); end
   endtask

   task automatic test_zero;
      int lat, bcnt;
      logic held;
      run(16'd0, -1, 16'd0, lat, bcnt, held);
      vecs++; if (lat !== 16) begin errs++; $display("FAIL zero_latency got %0d want 16", lat); end
      vecs++; if (bcd5 !== 20'h00000 || ovf5 !== 1'b0) begin errs++; $display("FAIL zero_result bcd=%h ovf=%b want 00000 0", bcd5, ovf5); end
      vecs++; if (blank5 !== B0) begin errs++; $display("FAIL zero_blank got %b want %b", blank5, B0); end
      @(negedge clk);
      vecs++; if (done5 !== 1'b0) begin errs++; $display("FAIL done_pulse got %b want 0", done5); end
   endtask

   task automatic test_max;
      int lat, bcnt;
      logic held;
      run(16'd65535, -1, 16'd0, lat, bcnt, held);
      vecs++; if (bcnt !== 16 || lat !== 16) begin errs++; $display("FAIL max_timing busy_cycles=%0d lat=%0d want 16 16", bcnt, lat); end
      vecs++; if (bcd5 !== 20'h65535 || ovf5 !== 1'b0) begin errs++; $display("FAIL max_result bcd=%h ovf=%b want 65535 0", bcd5, ovf5); end
      vecs++; if (blank5 !== 5'b00000) begin errs++; $display("FAIL max_blank got %b want 00000", blank5); end
      vecs++; if (held !== 1'b1) begin errs++; $display("FAIL max_hold got %b want 1", held); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int lat, bcnt;
      logic held;
      run(16'd1234, -1, 16'd0, lat, bcnt, held);
      vecs++; if (bcd5 !== 20'h01234 || blank5 !== B1234) begin errs++; $display("FAIL mid_result bcd=%h blank=%b want 01234 %b", bcd5, blank5, B1234); end
      run(16'd7, -1, 16'd0, lat, bcnt, held);
      vecs++; if (lat !== 16) begin errs++; $display("FAIL b2b_latency got %0d want 16", lat); end
      vecs++; if (held !== 1'b1) begin errs++; $display("FAIL b2b_hold got %b want 1", held); end
      vecs++; if (bcd5 !== 20'h00007 || blank5 !== B0) begin errs++; $display("FAIL b2b_result bcd=%h blank=%b want 00007 %b", bcd5, blank5, B0); end
      @(negedge clk);
   endtask

   task automatic test_overflow;
      int lat, bcnt;
      logic held;
      run(16'd12345, -1, 16'd0, lat, bcnt, held);
      vecs++; if (bcd4 !== 16'h2345 || ovf4 !== 1'b1) begin errs++; $display("FAIL ovf_result bcd=%h ovf=%b want 2345 1", bcd4, ovf4); end
      vecs++; if (blank4 !== 4'b0000) begin errs++; $display("FAIL ovf_blank got %b want 0000", blank4); end
      vecs++; if (bcd5 !== 20'h12345 || ovf5 !== 1'b0) begin errs++; $display("FAIL wide_result bcd=%h ovf=%b want 12345 0", bcd5, ovf5); end
      @(negedge clk);
      run(16'd99, -1, 16'd0, lat, bcnt, held);
      vecs++; if (bcd4 !== 16'h0099 || ovf4 !== 1'b0) begin errs++; $display("FAIL ovf_clear bcd=%h ovf=%b want 0099 0", bcd4, ovf4); end
      vecs++; if (blank4 !== B4_99) begin errs++; $display("FAIL ovf_clear_blank got %b want %b", blank4, B4_99); end
      @(negedge clk);
   endtask

   task automatic test_busy_start;
      int lat, bcnt, dn;
      logic held;
      run(16'd500, 4, 16'd9999, lat, bcnt, held);
      vecs++; if (lat !== 16) begin errs++; $display("FAIL busy_start_latency got %0d want 16", lat); end
      vecs++; if (bcd5 !== 20'h00500 || blank5 !== B500) begin errs++; $display("FAIL busy_start_result bcd=%h blank=%b want 00500 %b", bcd5, blank5, B500); end
      dn = 0;
      repeat (20) begin
         @(negedge clk);
         dn += int'(done5);
      end
      vecs++; if (dn !== 0) begin errs++; $display("FAIL busy_start_extra_done got %0d want 0", dn); end
   endtask

   task automatic test_reset_mid;
      int lat, bcnt, dn;
      logic held;
      start = 1'b1;
      bin   = 16'd40000;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      vecs++; if (busy5 !== 1'b1) begin errs++; $display("FAIL abort_pre_busy got %b want 1", busy5); end
      rst = 1'b1;
      #1;
      vecs++; if (busy5 !== 1'b0 || done5 !== 1'b0) begin errs++; $display("FAIL abort_ctl busy=%b done=%b want 0 0", busy5, done5); end
      vecs++; if (bcd5 !== 20'h0 || ovf5 !== 1'b0) begin errs++; $display("FAIL abort_out bcd=%h ovf=%b want 00000 0", bcd5, ovf5); end
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      repeat (20) begin
         @(negedge clk);
         dn += int'(done5);
      end
      vecs++; if (dn !== 0) begin errs++; $display("FAIL abort_done got %0d want 0", dn); end
      run(16'd42, -1, 16'd0, lat, bcnt, held);
      vecs++; if (lat !== 16 || bcd5 !== 20'h00042) begin errs++; $display("FAIL abort_next lat=%0d bcd=%h want 16 00042", lat, bcd5); end
      vecs++; if (blank5 !== B42) begin errs++; $display("FAIL abort_next_blank got %b want %b", blank5, B42); end
   endtask

   initial begin
      test_reset;
      test_zero;
      test_max;
      test_back_to_back;
      test_overflow;
      test_busy_start;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
